// File: rtl/wb_pkg.sv
// Shared constants, entry type and helpers for the writeback port arbiter.
// Optional performance counters in the top are enabled by defining WB_ARB_PERF_EN.
package wb_pkg;

  localparam int DW_DEF   = 16;
  localparam int RW_DEF   = 3;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 4;

  typedef struct packed {
    logic              valid;
    logic [RW_DEF-1:0] rd;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  function automatic logic multiHot(input logic [NREQ_MAX-1:0] v);
    return (v & (v - NREQ_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/wb_age_picker.sv
// Combinational one-hot grant: oldest full entry first; unordered (same-cycle)
// entries go round-robin from i_ptr, except same-rd pairs retire lower index first.
module wb_age_picker
  import wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int RW   = RW_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]      i_full,
  input  logic [NREQ*NREQ-1:0] i_older,
  input  logic [NREQ*RW-1:0]   i_rd,
  input  logic [PW-1:0]        i_ptr,
  output logic [NREQ-1:0]      o_grant
);

  logic [NREQ-1:0] w_eligible;
  logic [NREQ-1:0] w_cand;
  logic            w_found;

  // Bit j*NREQ+i set means entry j was captured before entry i.
  always_comb begin
    w_eligible = i_full;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (i_full[j] && i_older[j*NREQ+i]) begin
          w_eligible[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_cand = w_eligible;
    for (int i = 1; i < NREQ; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_eligible[j] && (i_rd[j*RW +: RW] == i_rd[i*RW +: RW])) begin
          w_cand[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && w_cand[i] && (i == ((int'(i_ptr) + k) % NREQ))) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NREQ one-entry writeback buffers,
// retiring oldest-first. Define WB_ARB_PERF_EN to add conflict_cnt/stall_cnt.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = DW_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*RW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               wb_en,
  output logic [RW-1:0]      wb_rd,
  output logic [DW-1:0]      wb_data,
  output logic [NREQ-1:0]    wb_src,
  output logic               busy
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0]        conflict_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_nreqCheck
    $error("wb_port_arbiter: NREQ=%0d outside supported range %0d..%0d", NREQ, NREQ_MIN, NREQ_MAX);
  end

  logic [NREQ-1:0]           r_full;
  logic [NREQ-1:0][RW-1:0]   r_rd;
  logic [NREQ-1:0][DW-1:0]   r_data;
  logic [NREQ-1:0][NREQ-1:0] r_older;
  logic [PW-1:0]             r_ptr;
  logic                      r_rstDone;

  logic [NREQ-1:0]           w_capture;
  logic [NREQ-1:0]           w_grant;
  logic [NREQ-1:0][NREQ-1:0] w_olderNext;
  logic [RW-1:0]             w_gntRd;
  logic [DW-1:0]             w_gntData;
  logic [PW-1:0]             w_ptrNext;

  // Ready is held low for the first cycle after reset release.
  assign req_ready = r_rstDone ? ~r_full : '0;
  assign w_capture = req_valid & req_ready;
  assign busy      = |r_full;

  wb_age_picker #(
    .NREQ(NREQ),
    .RW  (RW),
    .PW  (PW)
  ) u_picker (
    .i_full (r_full),
    .i_older(r_older),
    .i_rd   (r_rd),
    .i_ptr  (r_ptr),
    .o_grant(w_grant)
  );

  // A granted entry's row and column clear last, so it never orders a same-edge capture.
  always_comb begin
    w_olderNext = r_older;
    for (int i = 0; i < NREQ; i++) begin
      if (w_capture[i]) begin
        for (int j = 0; j < NREQ; j++) begin
          w_olderNext[i][j] = 1'b0;
          w_olderNext[j][i] = r_full[j] & ~w_capture[j];
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        for (int j = 0; j < NREQ; j++) begin
          w_olderNext[i][j] = 1'b0;
          w_olderNext[j][i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_gntRd   = '0;
    w_gntData = '0;
    w_ptrNext = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gntRd   = r_rd[i];
        w_gntData = r_data[i];
        w_ptrNext = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= '0;
      r_rd      <= '0;
      r_data    <= '0;
      r_older   <= '0;
      r_ptr     <= '0;
      r_rstDone <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_src    <= '0;
    end else begin
      r_rstDone <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end else if (w_capture[i]) begin
          r_full[i] <= 1'b1;
          r_rd[i]   <= req_rd[i*RW +: RW];
          r_data[i] <= req_data[i*DW +: DW];
        end
      end
      r_older <= w_olderNext;
      wb_en   <= |w_grant;
      if (|w_grant) begin
        r_ptr   <= w_ptrNext;
        wb_rd   <= w_gntRd;
        wb_data <= w_gntData;
        wb_src  <= w_grant;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic w_conflict;
  logic w_stall;

  assign w_conflict = multiHot(NREQ_MAX'(r_full));
  assign w_stall    = |(req_valid & ~req_ready);

  // Counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (w_conflict && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (w_stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a table of per-edge vectors plus
// hand-written backpressure and mid-flight reset sequences. Honours WB_ARB_PERF_EN.
module tb_wb_port_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int RW   = 3;

  logic        clk      = 1'b0;
  logic        rstN     = 1'b1;
  logic [2:0]  reqValid = '0;
  logic [2:0]  reqReady;
  logic [8:0]  reqRd    = '0;
  logic [47:0] reqData  = '0;
  logic        wbEn;
  logic [2:0]  wbRd;
  logic [15:0] wbData;
  logic [2:0]  wbSrc;
  logic        busy;
`ifdef WB_ARB_PERF_EN
  logic [15:0] conflictCnt;
  logic [15:0] stallCnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string       name;
    logic [2:0]  valid;
    logic [8:0]  rd;
    logic [47:0] data;
    logic        expEn;
    logic [2:0]  expRd;
    logic [15:0] expData;
    logic [2:0]  expSrc;
    logic [2:0]  expReady;
    logic        expBusy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .NREQ(NREQ),
    .DW  (DW),
    .RW  (RW)
  ) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_rd   (reqRd),
    .req_data (reqData),
    .wb_en    (wbEn),
    .wb_rd    (wbRd),
    .wb_data  (wbData),
    .wb_src   (wbSrc),
    .busy     (busy)
`ifdef WB_ARB_PERF_EN
    ,
    .conflict_cnt(conflictCnt),
    .stall_cnt   (stallCnt)
`endif
  );

  function automatic void addVec(input string name, input logic [2:0] valid,
                                 input logic [2:0] rd2, input logic [2:0] rd1, input logic [2:0] rd0,
                                 input logic [15:0] d2, input logic [15:0] d1, input logic [15:0] d0,
                                 input logic en, input logic [2:0] eRd, input logic [15:0] eData,
                                 input logic [2:0] eSrc, input logic [2:0] eReady, input logic eBusy);
    vec_t v;
    v.name     = name;
    v.valid    = valid;
    v.rd       = {rd2, rd1, rd0};
    v.data     = {d2, d1, d0};
    v.expEn    = en;
    v.expRd    = eRd;
    v.expData  = eData;
    v.expSrc   = eSrc;
    v.expReady = eReady;
    v.expBusy  = eBusy;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reqValid = v.valid;
    reqRd    = v.rd;
    reqData  = v.data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal({v.name, ".wb_en"},     wbEn,     v.expEn);
    checkVal({v.name, ".wb_rd"},     wbRd,     v.expRd);
    checkVal({v.name, ".wb_data"},   wbData,   v.expData);
    checkVal({v.name, ".wb_src"},    wbSrc,    v.expSrc);
    checkVal({v.name, ".req_ready"}, reqReady, v.expReady);
    checkVal({v.name, ".busy"},      busy,     v.expBusy);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //      name        valid   rd2   rd1   rd0   d2        d1        d0        en    rd    data      src     ready   busy
    addVec("t1Cap",    3'b001, 3'd0, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h00A5, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b110, 1'b1);
    addVec("t1Wr",     3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd3, 16'h00A5, 3'b001, 3'b111, 1'b0);
    addVec("t1Idle",   3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd3, 16'h00A5, 3'b001, 3'b111, 1'b0);
    addVec("lsuCap",   3'b100, 3'd0, 3'd0, 3'd0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 3'd3, 16'h00A5, 3'b001, 3'b011, 1'b1);
    addVec("lsuWr",    3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd0, 16'h0002, 3'b100, 3'b111, 1'b0);
    addVec("t2Cap",    3'b111, 3'd4, 3'd2, 3'd1, 16'h3333, 16'h2222, 16'h1111, 1'b0, 3'd0, 16'h0002, 3'b100, 3'b000, 1'b1);
    addVec("t2W0",     3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd1, 16'h1111, 3'b001, 3'b001, 1'b1);
    addVec("t2W1",     3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd2, 16'h2222, 3'b010, 3'b011, 1'b1);
    addVec("t2W2",     3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd4, 16'h3333, 3'b100, 3'b111, 1'b0);
    addVec("t2Idle",   3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd4, 16'h3333, 3'b100, 3'b111, 1'b0);
    addVec("ptrCap",   3'b001, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0010, 1'b0, 3'd4, 16'h3333, 3'b100, 3'b110, 1'b1);
    addVec("ptrWr",    3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd0, 16'h0010, 3'b001, 3'b111, 1'b0);
    addVec("sameRdCap",3'b011, 3'd0, 3'd7, 3'd7, 16'h0000, 16'hBBBB, 16'hAAAA, 1'b0, 3'd0, 16'h0010, 3'b001, 3'b100, 1'b1);
    addVec("sameRdW0", 3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'hAAAA, 3'b001, 3'b101, 1'b1);
    addVec("sameRdW1", 3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'hBBBB, 3'b010, 3'b111, 1'b0);
    addVec("ageCap",   3'b110, 3'd6, 3'd5, 3'd0, 16'h6666, 16'h5555, 16'h0000, 1'b0, 3'd7, 16'hBBBB, 3'b010, 3'b001, 1'b1);
    addVec("ageYoung", 3'b001, 3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000, 16'h5A5A, 1'b1, 3'd6, 16'h6666, 3'b100, 3'b100, 1'b1);
    addVec("ageOldWr", 3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd5, 16'h5555, 3'b010, 3'b110, 1'b1);
    addVec("ageYngWr", 3'b000, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'd5, 16'h5A5A, 3'b001, 3'b111, 1'b0);

    #1 rstN = 1'b0;
    @(posedge clk);
    #1;
    checkVal("rst.wb_en",     wbEn,     1'b0);
    checkVal("rst.wb_rd",     wbRd,     3'd0);
    checkVal("rst.wb_data",   wbData,   16'h0000);
    checkVal("rst.wb_src",    wbSrc,    3'b000);
    checkVal("rst.busy",      busy,     1'b0);
    checkVal("rst.req_ready", reqReady, 3'b000);
    @(posedge clk);
    #2 rstN = 1'b1;
    #1 checkVal("rel.readyHeld", reqReady, 3'b000);
    @(posedge clk);
    #1 checkVal("rel.readyUp", reqReady, 3'b111);
`ifdef WB_ARB_PERF_EN
    checkVal("rst.conflict_cnt", conflictCnt, 16'd0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Source holds its data until accepted, so accepted words are 0x0100, 0x0101, ...
    for (int k = 0; k < 8; k++) begin
      reqValid = 3'b001;
      reqRd    = {3'd0, 3'd0, 3'd2};
      reqData  = {32'h0, 16'h0100 + 16'(k / 2)};
      @(posedge clk);
      #1;
      if (k % 2 == 0) begin
        checkVal($sformatf("bp%0d.wb_en", k),     wbEn,     1'b0);
        checkVal($sformatf("bp%0d.req_ready", k), reqReady, 3'b110);
      end else begin
        checkVal($sformatf("bp%0d.wb_en", k),     wbEn,     1'b1);
        checkVal($sformatf("bp%0d.wb_rd", k),     wbRd,     3'd2);
        checkVal($sformatf("bp%0d.wb_data", k),   wbData,   16'h0100 + 16'(k / 2));
        checkVal($sformatf("bp%0d.wb_src", k),    wbSrc,    3'b001);
        checkVal($sformatf("bp%0d.req_ready", k), reqReady, 3'b111);
      end
    end
    reqValid = 3'b000;

    reqValid = 3'b111;
    reqRd    = {3'd1, 3'd2, 3'd3};
    reqData  = {16'h0C03, 16'h0C02, 16'h0C01};
    @(posedge clk);
    #1;
    checkVal("mid.fillReady", reqReady, 3'b000);
    checkVal("mid.fillBusy",  busy,     1'b1);
    reqValid = 3'b000;
    @(posedge clk);
    #1;
    checkVal("mid.wb_en",   wbEn,   1'b1);
    checkVal("mid.wb_src",  wbSrc,  3'b010);
    checkVal("mid.wb_data", wbData, 16'h0C02);
    #2 rstN = 1'b0;
    #1;
    checkVal("midRst.wb_en",     wbEn,     1'b0);
    checkVal("midRst.busy",      busy,     1'b0);
    checkVal("midRst.req_ready", reqReady, 3'b000);
    checkVal("midRst.wb_data",   wbData,   16'h0000);
    checkVal("midRst.wb_src",    wbSrc,    3'b000);
    @(posedge clk);
    @(posedge clk);
    #3 rstN = 1'b1;
    #1 checkVal("midRel.readyHeld", reqReady, 3'b000);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkVal($sformatf("midRel%0d.wb_en", k),     wbEn,     1'b0);
      checkVal($sformatf("midRel%0d.busy", k),      busy,     1'b0);
      checkVal($sformatf("midRel%0d.req_ready", k), reqReady, 3'b111);
    end
`ifdef WB_ARB_PERF_EN
    checkVal("midRel.conflict_cnt", conflictCnt, 16'd0);
    checkVal("midRel.stall_cnt",    stallCnt,    16'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback requesters: lane-0 ALU, lane-1 ALU and LSU load return.
- Each requester has a one-entry holding buffer. Each cycle the arbiter picks one buffered entry, oldest first, and drives a registered write strobe to the register file.
- Sits between the execute/memory stages and the register-file write port. It replaces the direct iswb/isld/rd/result path.

Parameters:
- NREQ, 3, number of requesters (2..4).
- DW, 16, writeback data width.
- RW, 3, register index width (2^RW registers).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i presents a writeback.
- req_ready  out  NREQ  holding buffer i is empty and can accept.
- req_rd  in  NREQ*RW  destination register per requester, slice i.
- req_data  in  NREQ*DW  result per requester, slice i.
- wb_en  out  1  register-file write strobe.
- wb_rd  out  RW  register-file write index.
- wb_data  out  DW  register-file write data.
- wb_src  out  NREQ  one-hot requester that produced the current write.
- busy  out  1  at least one holding buffer is full.

Behaviour:
- Reset (async assert, sync-released use):
  - All buffers empty; age matrix cleared; round-robin pointer = 0.
  - wb_en=0, wb_rd=0, wb_data=0, wb_src=0, busy=0.
  - req_ready goes to all-ones one cycle after rst_n deasserts.
- Accept:
  - req_ready[i] = ~full[i], registered-free, combinational from buffer state.
  - A transfer happens when req_valid[i] && req_ready[i]; rd and data are captured at that clock edge.
  - No same-cycle pass-through: a buffer freed this cycle shows ready next cycle.
- Age tracking:
  - NREQ x NREQ matrix; older[i][j]=1 means entry i was captured strictly before entry j.
  - On capture into i: older[j][i]=1 for every full j not also capturing this cycle.
  - Row i and column i are cleared when entry i is granted.
- Grant, one per cycle among full entries:
  - The oldest full entry wins.
  - Several entries with no age order between them (captured the same cycle) are broken round-robin from the pointer.
  - After any grant the pointer moves to granted index+1 mod NREQ.
- Write-after-write guarantee:
  - Two full entries with equal rd always retire in capture order, via the age rule.
  - Same-cycle captures to the same rd: the higher requester index is treated as program-younger and retires last, overriding round-robin for that pair.
- Latency:
  - Capture at edge N; earliest wb_en at edge N+1, with wb_rd, wb_data and wb_src registered.
  - wb_en is high for exactly one cycle per grant.
  - Throughput is 1 write/cycle.
- Simultaneous grant and capture on the same requester:
  - Not possible: the buffer is full, so ready=0.
  - The requester may capture again the cycle after its grant.
- All buffers empty: wb_en=0; wb_rd, wb_data and wb_src hold their last values.
- busy = |full.
- Reset mid-operation: pending entries are discarded, not written.
- Behaviour outside 2 ≤ NREQ ≤ 4 is undefined and must trip an elaboration-time $error.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- When defined:
  - Adds output conflict_cnt, 16 bits: counts cycles with ≥2 full buffers. Saturates at 16'hFFFF; cleared by reset.
  - Adds output stall_cnt, 16 bits: counts cycles where any req_valid[i]=1 with req_ready[i]=0. Saturating; cleared by reset.
- When undefined: neither port nor counter exists, and the core behaviour is identical.

Decomposition:
- Shared package wb_pkg: the DW/RW default constants, a typedef wb_entry_t {valid, rd, data}, and the NREQ limit constant.
- One natural sub-module, wb_age_picker: a combinational oldest-first pick with the round-robin tiebreak and same-rd override. Inputs are full, the age matrix, rd vector and pointer; output is a one-hot grant.
- Buffers, matrix and output registers live in the top module.

Test Plan:
- Single writer: after reset, lane0 sends rd=3, data=16'h00A5 at edge 1 -> wb_en=1, wb_rd=3, wb_data=00A5, wb_src=001 at edge 2; req_ready[0]=0 during cycle 1-2, 1 after.
- Same-cycle three-way: all three send rd=1/2/4 with data 1111/2222/3333 at edge 1, pointer 0 -> writes on edges 2, 3, 4 in order src 001, 010, 100; pointer ends at 0; busy falls after edge 4.
- Age beats round-robin: LSU captures rd=5 at edge 1 and lane0 captures rd=6 at edge 1 while lane1 is busy being granted -> LSU entry is written before any later lane0 capture with rd=5 arriving at edge 2; register 5 ends with the lane0 value.
- Same-rd same-cycle: lane0 and lane1 both send rd=7 (AAAA, BBBB) at edge 1 with pointer=1 -> AAAA is written first and BBBB last, despite the pointer.
- Backpressure: lane0 asserts valid every cycle with incrementing data, other lanes idle -> one write per 2 cycles, req_ready[0] toggles 1/0, no data lost or duplicated.
- Reset mid-flight: fill all 3 buffers, assert rst_n=0 asynchronously between edges -> wb_en drops immediately, no writes after release, req_ready=111 one cycle after release. With WB_ARB_PERF_EN, conflict_cnt=0.
